// File: rtl/int_scheduler.sv
// Machine interrupt scheduler: synchronises raw sources into a MIP image, picks a
// fixed-priority winner and runs the req/ack trap-entry handshake with a post-ack holdoff.
module int_scheduler #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF     = 4
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic        s_int_meip_i,
   input  logic        s_int_mtip_i,
   input  logic        s_int_msip_i,
   input  logic        s_int_uce_i,
   input  logic [12:0] s_mie_i,
   input  logic        s_mstatus_mie_i,
   input  logic        s_mret_i,
   input  logic        s_int_ack_i,
   output logic [12:0] s_mip_o,
   output logic        s_int_req_o,
   output logic [4:0]  s_int_code_o,
   output logic        s_busy_o
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, WAIT} state_t;

   localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF - 1);

   logic [3:0]  raw_w;
   logic [3:0]  sync_w;
   logic [12:0] mip_q;
   logic [12:0] eligible_w;
   logic [4:0]  winner_w;
   state_t      state_q;
   logic [4:0]  code_q;
   logic [3:0]  cnt_q;
   logic        req_q;
   logic [4:0]  code_out_q;
   logic        busy_q;

   // Bit order {UCE, MEI, MTI, MSI} keeps the MIP packing below readable.
   assign raw_w = {s_int_uce_i, s_int_meip_i, s_int_mtip_i, s_int_msip_i};

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign sync_w = raw_w;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0][3:0] sync_q;
         always_ff @(posedge s_clk_i) begin
            if (s_reset_i) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= raw_w;
               for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
         end
         assign sync_w = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) mip_q <= '0;
      else           mip_q <= {sync_w[3], sync_w[2], 3'b000, sync_w[1], 3'b000, sync_w[0], 3'b000};
   end

   assign eligible_w = mip_q & s_mie_i & {13{s_mstatus_mie_i}};

   always_comb begin
      winner_w = 5'd0;
      if      (eligible_w[12]) winner_w = 5'd12;
      else if (eligible_w[11]) winner_w = 5'd11;
      else if (eligible_w[3])  winner_w = 5'd3;
      else if (eligible_w[7])  winner_w = 5'd7;
   end

   // Outputs are registered alongside the state so req/code/busy never glitch.
   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         state_q    <= IDLE;
         code_q     <= '0;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         code_out_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (eligible_w != '0) begin
                  state_q    <= REQ;
                  code_q     <= winner_w;
                  req_q      <= 1'b1;
                  code_out_q <= winner_w;
                  busy_q     <= 1'b1;
               end
            end
            REQ: begin
               if (s_int_ack_i) begin
                  state_q    <= HOLD;
                  cnt_q      <= HOLD_INIT;
                  req_q      <= 1'b0;
                  code_out_q <= '0;
               end else if (!eligible_w[code_q[3:0]]) begin
                  state_q    <= IDLE;
                  req_q      <= 1'b0;
                  code_out_q <= '0;
                  busy_q     <= 1'b0;
               end
            end
            HOLD: begin
               if (cnt_q == 4'd0) state_q <= WAIT;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            WAIT: begin
               if (s_mret_i || s_mstatus_mie_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s_mip_o      = mip_q;
   assign s_int_req_o  = req_q;
   assign s_int_code_o = code_out_q;
   assign s_busy_o     = busy_q;

endmodule

// File: tb/tb_int_scheduler.sv
// Directed bench for int_scheduler: a behavioural model is compared every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_int_scheduler;
   localparam int SYNC = 2;
   localparam int HOLD_CYC = 4;

   logic        clk = 1'b0;
   logic        rst, meip, mtip, msip, uce, mst, mret, ack;
   logic [12:0] mie;
   logic [12:0] mip;
   logic        req, busy;
   logic [4:0]  code;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   int_scheduler #(.SYNC_STAGES(SYNC), .HOLDOFF(HOLD_CYC)) dut (
      .s_clk_i(clk), .s_reset_i(rst),
      .s_int_meip_i(meip), .s_int_mtip_i(mtip), .s_int_msip_i(msip), .s_int_uce_i(uce),
      .s_mie_i(mie), .s_mstatus_mie_i(mst), .s_mret_i(mret), .s_int_ack_i(ack),
      .s_mip_o(mip), .s_int_req_o(req), .s_int_code_o(code), .s_busy_o(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   // Model phases: 0 idle, 1 requesting, 2 holdoff, 3 waiting for mret/MIE.
   logic [12:0] hist[$];
   logic [12:0] m_mip = '0;
   logic [12:0] m_raw, m_elig;
   int          m_phase = 0;
   int          m_code = 0;
   int          m_hold_left = 0;

   function automatic int prio_pick(input logic [12:0] e);
      int order[4] = '{12, 11, 3, 7};
      for (int i = 0; i < 4; i++) if (e[order[i]]) return order[i];
      return 0;
   endfunction

   always @(posedge clk) begin
      m_raw = '0;
      m_raw[3] = msip; m_raw[7] = mtip; m_raw[11] = meip; m_raw[12] = uce;
      m_elig = m_mip & mie & {13{mst}};
      if (rst) begin
         hist.delete();
         for (int i = 0; i < SYNC; i++) hist.push_back('0);
         m_mip = '0; m_phase = 0; m_code = 0; m_hold_left = 0;
      end else begin
         case (m_phase)
            0: if (m_elig != 0) begin m_phase = 1; m_code = prio_pick(m_elig); end
            1: if (ack) begin m_phase = 2; m_hold_left = HOLD_CYC; end
               else if (!m_elig[m_code]) m_phase = 0;
            2: begin m_hold_left--; if (m_hold_left == 0) m_phase = 3; end
            default: if (mret || mst) m_phase = 0;
         endcase
         hist.push_back(m_raw);
         m_mip = hist.pop_front();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_mip", mip, m_mip);
         chk("model_req", req, m_phase == 1);
         chk("model_code", code, (m_phase == 1) ? m_code : 0);
         chk("model_busy", busy, m_phase != 0);
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1; meip = 1; mtip = 1; msip = 1; uce = 1;
      mie = 13'h1888; mst = 1; mret = 0; ack = 0;
      step(1);
      chk_en = 1'b1;
      step(2);
      chk("rst_mip", mip, 0); chk("rst_req", req, 0);
      chk("rst_code", code, 0); chk("rst_busy", busy, 0);

      meip = 0; mtip = 0; msip = 0; uce = 0; mie = 13'h888; rst = 0;
      step(4);

      // single MEI: visible in MIP 3 cycles after rise, request one cycle later
      meip = 1;
      step(3);
      chk("single_mip", mip, 13'h800); chk("single_req_early", req, 0);
      step(1);
      chk("single_req", req, 1); chk("single_code", code, 11);
      ack = 1; meip = 0;
      step(1);
      ack = 0;
      chk("single_hold_req", req, 0); chk("single_hold_busy", busy, 1);
      step(6);
      chk("single_idle", busy, 0);

      // priority: MSI beats MTI; MTI served after mret
      msip = 1; mtip = 1;
      step(4);
      chk("prio_req", req, 1); chk("prio_code", code, 3);
      ack = 1; mst = 0; msip = 0;
      step(1);
      ack = 0;
      step(8);
      chk("prio_wait_busy", busy, 1); chk("prio_wait_req", req, 0);
      mret = 1;
      step(1);
      mret = 0;
      chk("prio_mret_idle", busy, 0);
      mst = 1;
      step(1);
      chk("prio_mti_req", req, 1); chk("prio_mti_code", code, 7);
      ack = 1; mtip = 0;
      step(1);
      ack = 0;
      step(8);
      chk("prio_done", busy, 0);

      // withdraw: source drops while requesting, no ack
      meip = 1;
      step(4);
      chk("wd_req", req, 1);
      meip = 0;
      step(3);
      chk("wd_mip", mip, 0); chk("wd_req_hold", req, 1);
      step(1);
      chk("wd_req_drop", req, 0); chk("wd_busy", busy, 0);
      step(2);

      // ack and withdraw in the same cycle: holdoff must still be honoured
      meip = 1;
      step(4);
      chk("aw_req", req, 1); chk("aw_code", code, 11);
      ack = 1; mie = 13'h000;
      step(1);
      ack = 0; mie = 13'h888;
      chk("aw_req0", req, 0); chk("aw_busy", busy, 1);
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("aw_holdoff_req", req, 0);
      end
      step(1);
      chk("aw_rereq", req, 1);
      ack = 1; meip = 0;
      step(1);
      ack = 0;
      step(8);

      // stray ack while idle is ignored
      ack = 1;
      step(1);
      ack = 0;
      chk("stray_ack_busy", busy, 0);

      // global mask: all pending, nothing requested; then UCE wins
      mst = 0; mie = 13'h1888; meip = 1; mtip = 1; msip = 1; uce = 1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("mask_req", req, 0);
      end
      chk("mask_mip", mip, 13'h1888);
      mst = 1;
      step(1);
      chk("uce_req", req, 1); chk("uce_code", code, 12);

      // reset while requesting
      rst = 1;
      step(1);
      chk("midrst_req", req, 0); chk("midrst_busy", busy, 0); chk("midrst_mip", mip, 0);
      meip = 0; mtip = 0; msip = 0; uce = 0;
      step(2);
      rst = 0;
      step(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
